// File: rtl/zrle_decoder_if.sv
// ----------------------------------------------------------------------------
// zrle_decoder_if
// Handshake bundle for the ZNZ zero-run-length decoder.
//   Input stream  : znz_data, znz_last, znz_vld -> decoder, znz_rdy <- decoder
//   Output stream : is_one, last, vld <- decoder, rdy -> decoder
// Modports:
//   master : the side that feeds packed words and consumes decoded flags
//   slave  : the decoder itself
// ----------------------------------------------------------------------------
interface zrle_decoder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] znz_data;
    logic              znz_last;
    logic              znz_vld;
    logic              znz_rdy;
    logic              is_one;
    logic              last;
    logic              vld;
    logic              rdy;

    modport master (
        output znz_data, znz_last, znz_vld, rdy,
        input  znz_rdy, is_one, last, vld
    );

    modport slave (
        input  znz_data, znz_last, znz_vld, rdy,
        output znz_rdy, is_one, last, vld
    );
endinterface

// File: rtl/zrle_decoder.sv
// ----------------------------------------------------------------------------
// zrle_decoder
// Receive side of the EBPC zero/nonzero stream. Unpacks DATA_W-bit words
// MSB-first and expands the symbols into one is_one flag per element:
//   '1'                          -> one nonzero element
//   '0' + (L-1) on ZRLE_CNT_W    -> run of L zero elements
// Symbols may straddle words. Pad bits in the final word are ignored; the
// element count comes from num_elem_i.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   num_elem_i  element count, sampled on the first word accepted in IDLE
//   bus         zrle_decoder_if.slave
//                 znz_data/znz_last/znz_vld in, znz_rdy out (packed words)
//                 is_one/last/vld out, rdy in          (decoded flags)
//   idle_o      decoder in IDLE with no flag pending on the output
//   err_o       sticky error (only when ZRLE_DEC_ERR_EN is defined):
//               stream exhausted early, or a run overran the element count
//
// Build option: define ZRLE_DEC_ERR_EN to add err_o and its error logic.
// ----------------------------------------------------------------------------
module zrle_decoder #(
    parameter int DATA_W     = 8,
    parameter int ZRLE_CNT_W = 4,
    parameter int CNT_W      = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CNT_W-1:0]  num_elem_i,
    zrle_decoder_if.slave     bus,
    output logic              idle_o
`ifdef ZRLE_DEC_ERR_EN
    ,
    output logic              err_o
`endif
);

    localparam int PTR_W  = $clog2(DATA_W + 1);
    localparam int FCNT_W = $clog2(ZRLE_CNT_W + 1);
    localparam int RUN_W  = ZRLE_CNT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_RLEN,
        ST_ZEROS,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;

    // Word buffer: bits are consumed from the MSB, ptr_q counts bits left.
    logic [DATA_W-1:0]   buf_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                buf_last_q;

    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    elem_cnt_q;

    logic [ZRLE_CNT_W-1:0] field_q, field_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [RUN_W-1:0]    run_q, run_d;

    logic                out_vld_q;
    logic                out_one_q;
    logic                out_last_q;

    logic                slot_free;
    logic                bit_avail;
    logic                cur_bit;
    logic                buf_done;
    logic                last_hit;
    logic                consume;
    logic                emit;
    logic                emit_one;
    logic                flush;
    logic                znz_rdy;
    logic                accept;

    // Output register can take a new flag when empty or being drained now.
    assign slot_free = !out_vld_q || bus.rdy;
    assign bit_avail = (ptr_q != '0);
    assign cur_bit   = buf_q[DATA_W-1];
    // Final word of the stream fully consumed: nothing more will arrive.
    assign buf_done  = buf_last_q && !bit_avail;
    assign last_hit  = (elem_cnt_q + CNT_W'(1)) == num_q;

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        consume  = 1'b0;
        emit     = 1'b0;
        emit_one = 1'b0;
        flush    = 1'b0;
        field_d  = field_q;
        fcnt_d   = fcnt_q;
        run_d    = run_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.znz_vld) begin
                    state_d = (num_elem_i == '0) ? ST_DRAIN : ST_HEAD;
                end
            end

            ST_HEAD: begin
                if (buf_done) begin
                    state_d = ST_IDLE;               // exhausted between symbols
                end else if (bit_avail) begin
                    if (cur_bit) begin
                        if (slot_free) begin
                            consume  = 1'b1;
                            emit     = 1'b1;
                            emit_one = 1'b1;
                        end
                    end else begin
                        consume = 1'b1;
                        field_d = '0;
                        fcnt_d  = '0;
                        state_d = ST_RLEN;
                    end
                end
            end

            ST_RLEN: begin
                if (buf_done) begin
                    state_d = ST_IDLE;               // partial run header dropped
                end else if (bit_avail) begin
                    consume = 1'b1;
                    field_d = ZRLE_CNT_W'({field_q, cur_bit});
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    if (fcnt_q == FCNT_W'(ZRLE_CNT_W - 1)) begin
                        run_d   = RUN_W'(field_d) + RUN_W'(1);
                        state_d = ST_ZEROS;
                    end
                end
            end

            ST_ZEROS: begin
                if (slot_free) begin
                    emit  = 1'b1;
                    run_d = run_q - RUN_W'(1);
                    if (run_q == RUN_W'(1)) begin
                        state_d = ST_HEAD;
                    end
                end
            end

            ST_DRAIN: begin
                flush = 1'b1;
                if (buf_last_q || (bus.znz_vld && bus.znz_last)) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Element num_q reached: stop decoding. Skip DRAIN when the final
        // word has already been emptied by this very cycle.
        if (emit && last_hit) begin
            state_d = (buf_last_q && (ptr_q == PTR_W'(consume))) ? ST_IDLE : ST_DRAIN;
        end
    end

    // Refill without a bubble when the last buffered bit goes this cycle;
    // never pull a word past the final one of the current stream.
    always_comb begin
        znz_rdy = 1'b0;
        unique case (state_q)
            ST_IDLE:  znz_rdy = 1'b1;
            ST_DRAIN: znz_rdy = !buf_last_q;
            default:  znz_rdy = !buf_last_q &&
                                (!bit_avail || ((ptr_q == PTR_W'(1)) && consume));
        endcase
    end

    assign accept = bus.znz_vld && znz_rdy;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: reset is synchronous: it is only sampled on the clock edge, so
    // it sits inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            ptr_q      <= '0;
            buf_last_q <= 1'b0;
            num_q      <= '0;
            elem_cnt_q <= '0;
            field_q    <= '0;
            fcnt_q     <= '0;
            run_q      <= '0;
            out_vld_q  <= 1'b0;
            out_one_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            field_q <= field_d;
            fcnt_q  <= fcnt_d;
            run_q   <= run_d;

            if (accept) begin
                buf_q      <= bus.znz_data;
                ptr_q      <= PTR_W'(DATA_W);
                buf_last_q <= bus.znz_last;
            end else if (flush) begin
                ptr_q      <= '0;
            end else if (consume) begin
                buf_q      <= buf_q << 1;
                ptr_q      <= ptr_q - PTR_W'(1);
            end

            if (state_q == ST_IDLE && accept) begin
                num_q      <= num_elem_i;
                elem_cnt_q <= '0;
            end else if (emit) begin
                elem_cnt_q <= elem_cnt_q + CNT_W'(1);
            end

            if (slot_free) begin
                out_vld_q  <= emit;
                out_one_q  <= emit && emit_one;
                out_last_q <= emit && last_hit;
            end
        end
    end

`ifdef ZRLE_DEC_ERR_EN
    logic err_q;
    logic exhaust;
    logic trunc;

    assign exhaust = ((state_q == ST_HEAD) || (state_q == ST_RLEN)) && buf_done;
    assign trunc   = emit && last_hit && (state_q == ST_ZEROS) && (run_q != RUN_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && accept) begin
            err_q <= 1'b0;
        end else if (exhaust || trunc) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    assign bus.znz_rdy = znz_rdy;
    assign bus.vld     = out_vld_q;
    assign bus.is_one  = out_one_q;
    assign bus.last    = out_last_q;
    assign idle_o      = (state_q == ST_IDLE) && !out_vld_q;

endmodule
